// File: rtl/spi_burst_pkg.sv
// Shared types for the SPI burst RAM: command codes, FSM states and frame constants.
package spi_burst_pkg;

    localparam int CMD_BITS = 2;

    typedef enum logic [1:0] {
        WR_ADDR = 2'b00,
        WR_DATA = 2'b01,
        RD_ADDR = 2'b10,
        RD_DATA = 2'b11
    } cmd_e;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CMD     = 3'd1,
        ADDR    = 3'd2,
        WDATA   = 3'd3,
        RD_LOAD = 3'd4,
        RDATA   = 3'd5,
        HOLD    = 3'd6
    } state_e;

endpackage

// File: rtl/spi_burst_ram_mem.sv
// Word-wide RAM with one shared address: synchronous write, asynchronous read.
// Addresses at or above MEM_DEPTH are flagged out of range, never written,
// and read back as zero.
module spi_burst_ram_mem
    import spi_burst_pkg::*;
#(
    parameter int ADDR_SIZE  = 8,
    parameter int DATA_WIDTH = 8,
    parameter int MEM_DEPTH  = 256
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_SIZE-1:0]  addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  in_range
);

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    // One extra bit so MEM_DEPTH == 2**ADDR_SIZE is representable.
    assign in_range = ({1'b0, addr} < (ADDR_SIZE + 1)'(MEM_DEPTH));
    assign rdata    = in_range ? mem[addr] : '0;

    // Array write; the array is deliberately not reset.
    always_ff @(posedge clk) begin
        if (we && in_range) begin
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/spi_burst_ram.sv
// SPI slave front-end driving an on-chip RAM: 2-bit command frames, optional
// streaming bursts with wrapping auto-increment, sticky out-of-range flag.
module spi_burst_ram
    import spi_burst_pkg::*;
#(
    parameter int ADDR_SIZE  = 8,
    parameter int DATA_WIDTH = 8,
    parameter int MEM_DEPTH  = 256,
    parameter int BURST_EN   = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic SS_N,
    input  logic MOSI,
    output logic MISO,
    output logic busy,
    output logic addr_err
);

    localparam int CNT_MAX = (ADDR_SIZE > DATA_WIDTH) ? ADDR_SIZE : DATA_WIDTH;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(MEM_DEPTH - 1);

    state_e                state;
    cmd_e                  cmd_reg;
    cmd_e                  cmd_now;
    logic                  cmd_hi;
    logic [CNT_W-1:0]      bit_cnt;
    logic [ADDR_SIZE-1:0]  wr_addr;
    logic [ADDR_SIZE-1:0]  rd_addr;
    logic [ADDR_SIZE-1:0]  wr_addr_nx;
    logic [ADDR_SIZE-1:0]  rd_addr_nx;
    logic [ADDR_SIZE-1:0]  addr_shift;
    logic [ADDR_SIZE-1:0]  addr_shift_nx;
    logic [DATA_WIDTH-1:0] rx_shift;
    logic [DATA_WIDTH-1:0] rx_shift_nx;
    logic [DATA_WIDTH-1:0] tx_shift;
    logic [ADDR_SIZE-1:0]  mem_addr;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_we;
    logic                  in_range;
    logic                  addr_last;
    logic                  data_last;
    logic                  rd_access;

    // Auto-increment wraps at the end of the populated RAM, not at 2**ADDR_SIZE.
    function automatic logic [ADDR_SIZE-1:0] next_addr(input logic [ADDR_SIZE-1:0] a);
        return (a == LAST_ADDR) ? '0 : a + ADDR_SIZE'(1);
    endfunction

    assign cmd_now       = cmd_e'({cmd_hi, MOSI});
    assign addr_shift_nx = ADDR_SIZE'({addr_shift, MOSI});
    assign rx_shift_nx   = DATA_WIDTH'({rx_shift, MOSI});
    assign addr_last     = (bit_cnt == CNT_W'(ADDR_SIZE - 1));
    assign data_last     = (bit_cnt == CNT_W'(DATA_WIDTH - 1));
    assign wr_addr_nx    = next_addr(wr_addr);
    assign rd_addr_nx    = next_addr(rd_addr);
    assign busy          = (state != IDLE);

    // Write strobe fires on the edge that samples the last data bit of a word.
    assign mem_we    = rst_n && !SS_N && (state == WDATA) && data_last;
    // Read accesses: the initial load, and each burst reload at a word boundary.
    assign rd_access = rst_n && !SS_N &&
                       ((state == RD_LOAD) ||
                        ((state == RDATA) && data_last && (BURST_EN != 0)));

    // Single RAM port address: write pointer while writing, look-ahead while streaming reads.
    always_comb begin
        mem_addr = rd_addr;
        case (state)
            WDATA:   mem_addr = wr_addr;
            RDATA:   mem_addr = rd_addr_nx;
            default: mem_addr = rd_addr;
        endcase
    end

    spi_burst_ram_mem #(
        .ADDR_SIZE  (ADDR_SIZE),
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH)
    ) u_mem (
        .clk      (clk),
        .we       (mem_we),
        .addr     (mem_addr),
        .wdata    (rx_shift_nx),
        .rdata    (mem_rdata),
        .in_range (in_range)
    );

    // Frame decoder: command, address and data shifting, address pointers and MISO.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cmd_reg    <= WR_ADDR;
            cmd_hi     <= 1'b0;
            bit_cnt    <= '0;
            wr_addr    <= '0;
            rd_addr    <= '0;
            addr_shift <= '0;
            rx_shift   <= '0;
            tx_shift   <= '0;
            MISO       <= 1'b0;
        end else if (SS_N) begin
            state   <= IDLE;
            bit_cnt <= '0;
            MISO    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cmd_hi <= MOSI;
                    state  <= CMD;
                end
                CMD: begin
                    cmd_reg    <= cmd_now;
                    bit_cnt    <= '0;
                    addr_shift <= '0;
                    rx_shift   <= '0;
                    case (cmd_now)
                        WR_ADDR, RD_ADDR: state <= ADDR;
                        WR_DATA:          state <= WDATA;
                        default:          state <= RD_LOAD;
                    endcase
                end
                ADDR: begin
                    addr_shift <= addr_shift_nx;
                    bit_cnt    <= bit_cnt + CNT_W'(1);
                    if (addr_last) begin
                        if (cmd_reg == RD_ADDR) begin
                            rd_addr <= addr_shift_nx;
                        end else begin
                            wr_addr <= addr_shift_nx;
                        end
                        state <= HOLD;
                    end
                end
                WDATA: begin
                    rx_shift <= rx_shift_nx;
                    bit_cnt  <= bit_cnt + CNT_W'(1);
                    if (data_last) begin
                        bit_cnt <= '0;
                        if (BURST_EN != 0) begin
                            wr_addr <= wr_addr_nx;
                        end else begin
                            state <= HOLD;
                        end
                    end
                end
                RD_LOAD: begin
                    tx_shift <= mem_rdata << 1;
                    MISO     <= mem_rdata[DATA_WIDTH-1];
                    bit_cnt  <= '0;
                    state    <= RDATA;
                end
                RDATA: begin
                    if (data_last) begin
                        if (BURST_EN != 0) begin
                            rd_addr  <= rd_addr_nx;
                            tx_shift <= mem_rdata << 1;
                            MISO     <= mem_rdata[DATA_WIDTH-1];
                            bit_cnt  <= '0;
                        end else begin
                            MISO  <= 1'b0;
                            state <= HOLD;
                        end
                    end else begin
                        MISO     <= tx_shift[DATA_WIDTH-1];
                        tx_shift <= tx_shift << 1;
                        bit_cnt  <= bit_cnt + CNT_W'(1);
                    end
                end
                HOLD: begin
                    state <= HOLD;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Sticky out-of-range flag, set by any suppressed write or zeroed read.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_err <= 1'b0;
        end else if ((mem_we || rd_access) && !in_range) begin
            addr_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_spi_burst_ram.sv
// Directed bench for spi_burst_ram: three instances cover the default
// configuration, a 200-word RAM and single-word (non-burst) mode.
module tb_spi_burst_ram;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] ss_n;
    logic [2:0] mosi;
    wire  [2:0] miso;
    wire  [2:0] busy;
    wire  [2:0] addr_err;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    spi_burst_ram #(.ADDR_SIZE(8), .DATA_WIDTH(8), .MEM_DEPTH(256), .BURST_EN(1)) dut_def (
        .clk(clk), .rst_n(rst_n), .SS_N(ss_n[0]), .MOSI(mosi[0]),
        .MISO(miso[0]), .busy(busy[0]), .addr_err(addr_err[0])
    );

    spi_burst_ram #(.ADDR_SIZE(8), .DATA_WIDTH(8), .MEM_DEPTH(200), .BURST_EN(1)) dut_d200 (
        .clk(clk), .rst_n(rst_n), .SS_N(ss_n[1]), .MOSI(mosi[1]),
        .MISO(miso[1]), .busy(busy[1]), .addr_err(addr_err[1])
    );

    spi_burst_ram #(.ADDR_SIZE(8), .DATA_WIDTH(8), .MEM_DEPTH(256), .BURST_EN(0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .SS_N(ss_n[2]), .MOSI(mosi[2]),
        .MISO(miso[2]), .busy(busy[2]), .addr_err(addr_err[2])
    );

    // One SPI edge: drive at the falling edge, return just after the rising edge.
    task automatic step(input int d, input logic ss, input logic b);
        @(negedge clk);
        ss_n[d] = ss;
        mosi[d] = b;
        @(posedge clk);
        #1;
    endtask

    // Full frame: command, nbits payload MSB first (MISO captured per bit), then SS_N high.
    task automatic frame(input int d, input logic [1:0] cmd, input logic [31:0] payload,
                         input int nbits, output logic [31:0] rx,
                         output logic busy_ok, output logic busy_after);
        rx      = '0;
        busy_ok = 1'b1;
        step(d, 1'b0, cmd[1]);
        busy_ok &= busy[d];
        step(d, 1'b0, cmd[0]);
        busy_ok &= busy[d];
        for (int i = nbits - 1; i >= 0; i--) begin
            step(d, 1'b0, payload[i]);
            busy_ok &= busy[d];
            rx = {rx[30:0], miso[d]};
        end
        step(d, 1'b1, 1'b0);
        busy_after = busy[d];
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        ss_n  = 3'b111;
        mosi  = 3'b000;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (miso[d] !== 1'b0) begin
                fails++;
                $display("[TB] FAIL reset_miso dut%0d got %b want 0", d, miso[d]);
            end
            checks++;
            if (busy[d] !== 1'b0) begin
                fails++;
                $display("[TB] FAIL reset_busy dut%0d got %b want 0", d, busy[d]);
            end
            checks++;
            if (addr_err[d] !== 1'b0) begin
                fails++;
                $display("[TB] FAIL reset_addr_err dut%0d got %b want 0", d, addr_err[d]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [31:0] rx;
        logic        bok;
        logic        baft;
        logic [7:0]  exp_word;
        exp_word = 8'hA5;
        frame(0, 2'b00, 32'h10, 8, rx, bok, baft);
        checks++;
        if (bok !== 1'b1) begin
            fails++;
            $display("[TB] FAIL basic_busy_wraddr got %b want 1", bok);
        end
        frame(0, 2'b01, 32'hA5, 8, rx, bok, baft);
        checks++;
        if (bok !== 1'b1) begin
            fails++;
            $display("[TB] FAIL basic_busy_wrdata got %b want 1", bok);
        end
        frame(0, 2'b10, 32'h10, 8, rx, bok, baft);
        frame(0, 2'b11, 32'h0, 8, rx, bok, baft);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (rx[7-i] !== exp_word[7-i]) begin
                fails++;
                $display("[TB] FAIL basic_miso_edge%0d got %b want %b", i + 2, rx[7-i], exp_word[7-i]);
            end
        end
        checks++;
        if (bok !== 1'b1 || baft !== 1'b0) begin
            fails++;
            $display("[TB] FAIL basic_busy_read got %b/%b want 1/0", bok, baft);
        end
        checks++;
        if (addr_err[0] !== 1'b0) begin
            fails++;
            $display("[TB] FAIL basic_addr_err got %b want 0", addr_err[0]);
        end
    endtask

    task automatic test_burst();
        logic [31:0] rx;
        logic        bok;
        logic        baft;
        frame(0, 2'b00, 32'hFE, 8, rx, bok, baft);
        frame(0, 2'b01, 32'h112233, 24, rx, bok, baft);
        frame(0, 2'b10, 32'hFE, 8, rx, bok, baft);
        frame(0, 2'b11, 32'h0, 24, rx, bok, baft);
        checks++;
        if (rx[23:0] !== 24'h112233) begin
            fails++;
            $display("[TB] FAIL burst_read_wrap got %h want 112233", rx[23:0]);
        end
        frame(0, 2'b10, 32'h00, 8, rx, bok, baft);
        frame(0, 2'b11, 32'h0, 8, rx, bok, baft);
        checks++;
        if (rx[7:0] !== 8'h33) begin
            fails++;
            $display("[TB] FAIL burst_mem00 got %h want 33", rx[7:0]);
        end
    endtask

    task automatic test_abort();
        logic [31:0] rx;
        logic        bok;
        logic        baft;
        frame(0, 2'b00, 32'h20, 8, rx, bok, baft);
        frame(0, 2'b01, 32'h5C, 8, rx, bok, baft);
        frame(0, 2'b00, 32'h20, 8, rx, bok, baft);
        frame(0, 2'b01, 32'h1F, 5, rx, bok, baft);
        checks++;
        if (baft !== 1'b0) begin
            fails++;
            $display("[TB] FAIL abort_busy got %b want 0", baft);
        end
        frame(0, 2'b10, 32'h20, 8, rx, bok, baft);
        frame(0, 2'b11, 32'h0, 8, rx, bok, baft);
        checks++;
        if (rx[7:0] !== 8'h5C) begin
            fails++;
            $display("[TB] FAIL abort_mem20 got %h want 5c", rx[7:0]);
        end
    endtask

    task automatic test_reset_mid_read();
        logic [31:0] rx;
        logic        bok;
        logic        baft;
        frame(0, 2'b10, 32'h20, 8, rx, bok, baft);
        step(0, 1'b0, 1'b1);
        step(0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(0, 1'b0, 1'b0);
        end
        checks++;
        if (miso[0] !== 1'b1) begin
            fails++;
            $display("[TB] FAIL midread_bit3 got %b want 1", miso[0]);
        end
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (miso[0] !== 1'b0 || busy[0] !== 1'b0 || addr_err[0] !== 1'b0) begin
            fails++;
            $display("[TB] FAIL midread_reset got miso=%b busy=%b err=%b want 0/0/0",
                     miso[0], busy[0], addr_err[0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 1'b1, 1'b0);
        frame(0, 2'b11, 32'h0, 8, rx, bok, baft);
        checks++;
        if (rx[7:0] !== 8'h33) begin
            fails++;
            $display("[TB] FAIL midread_restart_addr0 got %h want 33", rx[7:0]);
        end
    endtask

    task automatic test_depth200();
        logic [31:0] rx;
        logic        bok;
        logic        baft;
        frame(1, 2'b00, 32'hC7, 8, rx, bok, baft);
        frame(1, 2'b01, 32'hABCD, 16, rx, bok, baft);
        frame(1, 2'b10, 32'hC7, 8, rx, bok, baft);
        frame(1, 2'b11, 32'h0, 16, rx, bok, baft);
        checks++;
        if (rx[15:0] !== 16'hABCD) begin
            fails++;
            $display("[TB] FAIL d200_wrap199 got %h want abcd", rx[15:0]);
        end
        frame(1, 2'b00, 32'hD0, 8, rx, bok, baft);
        checks++;
        if (addr_err[1] !== 1'b0) begin
            fails++;
            $display("[TB] FAIL d200_err_before got %b want 0", addr_err[1]);
        end
        frame(1, 2'b01, 32'h77, 8, rx, bok, baft);
        checks++;
        if (addr_err[1] !== 1'b1) begin
            fails++;
            $display("[TB] FAIL d200_err_write got %b want 1", addr_err[1]);
        end
        frame(1, 2'b10, 32'hD0, 8, rx, bok, baft);
        frame(1, 2'b11, 32'h0, 8, rx, bok, baft);
        checks++;
        if (rx[7:0] !== 8'h00) begin
            fails++;
            $display("[TB] FAIL d200_read_oor got %h want 00", rx[7:0]);
        end
        checks++;
        if (addr_err[1] !== 1'b1) begin
            fails++;
            $display("[TB] FAIL d200_err_sticky got %b want 1", addr_err[1]);
        end
    endtask

    task automatic test_no_burst();
        logic [31:0] rx;
        logic        bok;
        logic        baft;
        frame(2, 2'b00, 32'h06, 8, rx, bok, baft);
        frame(2, 2'b01, 32'h99, 8, rx, bok, baft);
        frame(2, 2'b00, 32'h05, 8, rx, bok, baft);
        frame(2, 2'b01, 32'h0102, 16, rx, bok, baft);
        checks++;
        if (bok !== 1'b1 || baft !== 1'b0) begin
            fails++;
            $display("[TB] FAIL nb_hold_busy got %b/%b want 1/0", bok, baft);
        end
        frame(2, 2'b10, 32'h05, 8, rx, bok, baft);
        frame(2, 2'b11, 32'h0, 16, rx, bok, baft);
        checks++;
        if (rx[15:0] !== 16'h0100) begin
            fails++;
            $display("[TB] FAIL nb_read_single got %h want 0100", rx[15:0]);
        end
        frame(2, 2'b10, 32'h06, 8, rx, bok, baft);
        frame(2, 2'b11, 32'h0, 8, rx, bok, baft);
        checks++;
        if (rx[7:0] !== 8'h99) begin
            fails++;
            $display("[TB] FAIL nb_mem06 got %h want 99", rx[7:0]);
        end
    endtask

    // Sequence the scenarios and report.
    initial begin
        rst_n = 1'b0;
        ss_n  = 3'b111;
        mosi  = 3'b000;
        test_reset();
        test_basic();
        test_burst();
        test_abort();
        test_reset_mid_read();
        test_depth200();
        test_no_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    // Bound on total run time.
    initial begin
        #500000;
        $display("[TB] FAIL timeout got running want finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
